// File: rtl/sram_sp_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_sp_ctrl
// Brief   : Read/write request arbiter, zero-fill sweep and read-data hold
//           for a single-port RW0 SRAM macro.
// Revision: 1.0 - initial release
// ============================================================================
module sram_sp_ctrl #(
  parameter int SETS         = 256,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 66,
  parameter int SHOULD_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic [ADDR_W-1:0] w_req_setIdx,
  input  logic [DATA_W-1:0] w_req_data,
  input  logic              r_req_valid,
  output logic              r_req_ready,
  input  logic [ADDR_W-1:0] r_req_setIdx,
  output logic              r_resp_valid,
  output logic [DATA_W-1:0] r_resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t            c_RST_STATE = (SHOULD_RESET != 0) ? ST_INIT : ST_RUN;
  localparam logic              c_RST_DONE  = (SHOULD_RESET == 0);
  localparam logic [ADDR_W-1:0] c_LAST      = ADDR_W'(SETS - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_init_done;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_hold;
  logic                w_wr_ready;
  logic                w_rd_ready;
  logic                w_wfire;
  logic                w_rfire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= c_RST_STATE;
      r_cnt       <= '0;
      r_init_done <= c_RST_DONE;
      r_rvalid    <= 1'b0;
      r_hold      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_rfire;
      if (w_state_nxt == ST_RUN) begin
        r_init_done <= 1'b1;
      end
      // Capture the macro output only in the cycle it is valid.
      if (r_rvalid) begin
        r_hold <= RW0_rdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_ready  = 1'b0;
    w_rd_ready  = 1'b0;
    w_wfire     = 1'b0;
    w_rfire     = 1'b0;
    RW0_en      = 1'b0;
    RW0_wmode   = 1'b0;
    RW0_addr    = '0;
    RW0_wdata   = '0;

    case (r_state)
      ST_INIT: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_addr  = r_cnt;
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        w_wr_ready = 1'b1;
        w_rd_ready = !w_req_valid;
        w_wfire    = w_req_valid;
        w_rfire    = r_req_valid && !w_req_valid;
        if (w_wfire) begin
          RW0_en    = 1'b1;
          RW0_wmode = 1'b1;
          RW0_addr  = w_req_setIdx;
          RW0_wdata = w_req_data;
        end else if (w_rfire) begin
          RW0_en   = 1'b1;
          RW0_addr = r_req_setIdx;
        end
      end
      default: begin
        w_state_nxt = c_RST_STATE;
      end
    endcase

    // Keep the macro idle and refuse requests while reset is held.
    if (reset) begin
      w_wr_ready = 1'b0;
      w_rd_ready = 1'b0;
      w_wfire    = 1'b0;
      w_rfire    = 1'b0;
      RW0_en     = 1'b0;
    end
  end

  assign w_req_ready  = w_wr_ready;
  assign r_req_ready  = w_rd_ready;
  assign r_resp_valid = r_rvalid;
  assign r_resp_data  = r_rvalid ? RW0_rdata : r_hold;
  assign init_done    = r_init_done;

endmodule
`default_nettype wire

// File: doc/sram_sp_ctrl.md
Name: sram_sp_ctrl

Overview:
Request-side controller for the 256x66 single-port SRAM macro array. It arbitrates independent read and write request channels onto the macro's single RW0 port, giving writes priority. After reset it clears every set to zero with a sweep. It also holds read data stable after the macro's one-cycle read until the next read is issued. It sits directly upstream of the macro and drives RW0_addr/en/wmode/wdata. The macro's RW0_clk is tied to the same clock.

Parameters:
SETS, 256, number of entries; must equal macro depth
ADDR_W, 8, set index width, log2(SETS)
DATA_W, 66, entry width
SHOULD_RESET, 1, 1 = zero-fill sweep after reset; 0 = ready immediately after reset

Ports:
clock  input  1  single clock for controller and macro
reset  input  1  asynchronous, active-high reset
w_req_valid  input  1  write request valid
w_req_ready  output  1  write request accepted when valid&&ready
w_req_setIdx  input  ADDR_W  write set index
w_req_data  input  DATA_W  write data
r_req_valid  input  1  read request valid
r_req_ready  output  1  read request accepted when valid&&ready
r_req_setIdx  input  ADDR_W  read set index
r_resp_valid  output  1  one-cycle pulse, cycle after read accept
r_resp_data  output  DATA_W  read data; held stable until next accepted read
init_done  output  1  high once reset sweep complete
RW0_addr  output  ADDR_W  macro address
RW0_en  output  1  macro enable
RW0_wmode  output  1  macro write mode (1 = write)
RW0_wdata  output  DATA_W  macro write data
RW0_rdata  input  DATA_W  macro read data, valid the cycle after a read enable

Behaviour:
- Reset values: state=INIT (SHOULD_RESET=1) or RUN (0); init counter=0; init_done=0 (1 if SHOULD_RESET=0); r_resp_valid=0; hold register=0; RW0_en=0.
- The control outputs RW0_* are combinational from state and requests; there is no extra pipeline stage before the macro.
- INIT state: each cycle RW0_en=1, RW0_wmode=1, RW0_addr=counter, RW0_wdata=0; counter increments.
- INIT to RUN: the transition happens after the write at counter==SETS-1, so the sweep takes exactly SETS cycles. The counter does not wrap back into INIT.
- While in INIT, w_req_ready=0 and r_req_ready=0; incoming requests are ignored, not queued.
- init_done registers high on the first RUN cycle and stays high until reset.
- RUN state: w_req_ready=1 and r_req_ready=!w_req_valid.
  - Write fire: RW0_en=1, wmode=1, addr=w_req_setIdx, wdata=w_req_data.
  - Read fire: RW0_en=1, wmode=0, addr=r_req_setIdx.
  - Neither fires: RW0_en=0.
- Simultaneous read and write valid: the write wins and the read stalls (ready=0). The read must hold valid and setIdx stable.
- Read latency is 1 cycle. In cycle N+1 after a read fire in cycle N:
  - r_resp_valid=1;
  - r_resp_data=RW0_rdata;
  - the hold register captures RW0_rdata.
- In every later cycle with no read fire in the prior cycle, r_resp_valid=0 and r_resp_data=hold register. This keeps data stable even if a later write targets the same set.
- Back-to-back reads are fully supported: a read fire every cycle gives r_resp_valid high every cycle.
- Read in cycle N+1 of a set written in cycle N returns the new data. No same-cycle read/write hazard exists because the port is exclusive.
- Asynchronous reset mid-sweep or mid-read behaves as follows:
  - The controller returns immediately to the reset values.
  - A pending r_resp_valid is dropped.
  - The sweep restarts from set 0 after reset deasserts.
- The width of setIdx is ADDR_W. Indices >= SETS are illegal when SETS is not a power of two; this is not checked.

Test Plan:
- Reset then idle (SHOULD_RESET=1) -> exactly 256 cycles of RW0_en=1/wmode=1 with addr 0..255 and wdata 0; init_done rises in cycle 257; readies are 0 throughout the sweep.
- After init, read set 0x37 -> r_resp_valid pulse 1 cycle later with data 0; readback of all 256 sets returns 0.
- Write 0x3_FFFF_FFFF_FFFF_FFFF to set 0x10, then read 0x10 the next cycle -> response equals 0x3_FFFF_FFFF_FFFF_FFFF.
- Read valid and write valid in the same cycle -> write issued first with r_req_ready=0; read issued the following cycle; response reflects the new data if the sets match.
- Read set 5 (data A), then write set 5 with B for 3 cycles with no read -> r_resp_data stays A until the next read, which returns B.
- Assert reset at sweep counter 100 -> RW0_en=0 and init_done=0 during reset; after release the sweep restarts at addr 0 and takes a full 256 cycles.
